// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants and address-width helper
package regfile_pkg;
  localparam int DEF_WORD_LENGTH = 32;
  localparam int DEF_NREGS = 32;
  localparam int GROUP_SIZE = 8;
  localparam int GROUP_BITS = 3;
  function automatic int CeilLog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/regfile_read_port_if.sv
// regfile_read_port_if: read request / response handshake bundle
interface regfile_read_port_if import regfile_pkg::*; #(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int NREGS = DEF_NREGS
);
  localparam int NBITS = CeilLog2(NREGS);
  logic                   Rd_Valid;
  logic                   Rd_Ready;
  logic [NBITS-1:0]       Rd_Address;
  logic                   Rsp_Valid;
  logic                   Rsp_Ready;
  logic [WORD_LENGTH-1:0] Rsp_Data;
  logic [NBITS-1:0]       Rsp_Address;
  modport master (output Rd_Valid, Rd_Address, Rsp_Ready, input Rd_Ready, Rsp_Valid, Rsp_Data, Rsp_Address);
  modport slave  (input Rd_Valid, Rd_Address, Rsp_Ready, output Rd_Ready, Rsp_Valid, Rsp_Data, Rsp_Address);
endinterface

// File: rtl/regfile_mux8.sv
// regfile_mux8: combinational 8:1 word select
module regfile_mux8 import regfile_pkg::*; #(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH
) (
  input  logic [GROUP_SIZE-1:0][WORD_LENGTH-1:0] words,
  input  logic [GROUP_BITS-1:0]                  sel,
  output logic [WORD_LENGTH-1:0]                 y
);
  // Pick one word of the group
  always_comb y = words[sel];
endmodule

// File: rtl/regfile_read_port.sv
// regfile_read_port: two-stage pipelined register read with valid/ready; optional WRITE_BYPASS_EN forwards a same-edge write
module regfile_read_port import regfile_pkg::*; #(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int NREGS = DEF_NREGS,
  parameter int ZERO_REG = 1,
  localparam int NBITS = CeilLog2(NREGS)
) (
  input logic                         clk,
  input logic                         reset,
  regfile_read_port_if.slave          bus,
  input logic [NREGS*WORD_LENGTH-1:0] Reg_Data
`ifdef WRITE_BYPASS_EN
  ,input logic                   Wr_Enable
  ,input logic [NBITS-1:0]       Wr_Address
  ,input logic [WORD_LENGTH-1:0] Wr_Data
`endif
);
  typedef logic [WORD_LENGTH-1:0] word_t;
  word_t [NREGS-1:0] regs;
  word_t [GROUP_SIZE-1:0] cap_words, s1_words_q, s1_words_d;
  logic [NBITS-1:0] grp_base, s1_addr_q, s1_addr_d, rsp_addr_q, rsp_addr_d;
  logic s1_valid_q, s1_valid_d, rsp_valid_q, rsp_valid_d;
  logic s2_free, s1_move, rd_ready, accept;
  word_t s2_word, rsp_data_q, rsp_data_d;
  assign regs = Reg_Data;
  assign grp_base = bus.Rd_Address & ~NBITS'(GROUP_SIZE - 1);
  // Snapshot the addressed group; forwarding then the zero register override the requested word
  always_comb begin
    cap_words = '0;
    for (int i = 0; i < GROUP_SIZE; i++) cap_words[i] = regs[grp_base | NBITS'(i)];
`ifdef WRITE_BYPASS_EN
    if (Wr_Enable && Wr_Address == bus.Rd_Address) cap_words[bus.Rd_Address[GROUP_BITS-1:0]] = Wr_Data;
`endif
    if (ZERO_REG != 0 && bus.Rd_Address == '0) cap_words[0] = '0;
  end
  regfile_mux8 #(.WORD_LENGTH(WORD_LENGTH)) u_mux (
    .words(s1_words_q),
    .sel  (s1_addr_q[GROUP_BITS-1:0]),
    .y    (s2_word)
  );
  // Handshake and pipeline advance: S1 refills whenever it is empty or draining into S2
  always_comb begin
    s2_free = !rsp_valid_q || bus.Rsp_Ready;
    s1_move = s1_valid_q && s2_free;
    rd_ready = !s1_valid_q || s2_free;
    accept = bus.Rd_Valid && rd_ready;
    s1_valid_d = accept || (s1_valid_q && !s1_move);
    s1_words_d = accept ? cap_words : s1_words_q;
    s1_addr_d = accept ? bus.Rd_Address : s1_addr_q;
    rsp_valid_d = s1_move || (rsp_valid_q && !bus.Rsp_Ready);
    rsp_data_d = s1_move ? s2_word : rsp_data_q;
    rsp_addr_d = s1_move ? s1_addr_q : rsp_addr_q;
  end
  // Valid flags and response registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_addr_q <= rsp_addr_d;
    end
  end
  // S1 payload is qualified by s1_valid_q and needs no reset
  always_ff @(posedge clk) begin
    s1_words_q <= s1_words_d;
    s1_addr_q <= s1_addr_d;
  end
  assign bus.Rd_Ready = rd_ready;
  assign bus.Rsp_Valid = rsp_valid_q;
  assign bus.Rsp_Data = rsp_data_q;
  assign bus.Rsp_Address = rsp_addr_q;
endmodule

// File: tb/tb_regfile_read_port.sv
// tb_regfile_read_port: scoreboard bench driving a ZERO_REG=1 and a ZERO_REG=0 instance in lockstep
module tb_regfile_read_port;
  localparam int W = 32;
  localparam int N = 32;
  localparam int NB = 5;
`ifdef WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0][W-1:0] regs;
  logic wr_en = 1'b0;
  logic [NB-1:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  int n_chk = 0;
  int n_err = 0;
  logic [NB+W-1:0] q1[$];
  logic [NB+W-1:0] q0[$];
  logic [NB+W-1:0] e1, e0;
  logic h1 = 1'b0, h0 = 1'b0;
  logic [W-1:0] hd1, hd0;
  bit r;

  regfile_read_port_if #(.WORD_LENGTH(W), .NREGS(N)) bus ();
  regfile_read_port_if #(.WORD_LENGTH(W), .NREGS(N)) bus0 ();
  assign bus0.Rd_Valid = bus.Rd_Valid;
  assign bus0.Rd_Address = bus.Rd_Address;
  assign bus0.Rsp_Ready = bus.Rsp_Ready;

  regfile_read_port #(.WORD_LENGTH(W), .NREGS(N), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .Reg_Data(regs)
`ifdef WRITE_BYPASS_EN
    , .Wr_Enable(wr_en), .Wr_Address(wr_addr), .Wr_Data(wr_data)
`endif
  );
  regfile_read_port #(.WORD_LENGTH(W), .NREGS(N), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .reset(reset), .bus(bus0), .Reg_Data(regs)
`ifdef WRITE_BYPASS_EN
    , .Wr_Enable(wr_en), .Wr_Address(wr_addr), .Wr_Data(wr_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [NB-1:0] a, input bit zr);
    logic [W-1:0] v;
    v = regs[a];
    if (BYPASS && wr_en && wr_addr == a) v = wr_data;
    if (zr && a == '0) v = '0;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      q1.delete();
      q0.delete();
      h1 = 1'b0;
      h0 = 1'b0;
    end else begin
      if (h1) begin
        chk("hold1_valid", 64'(bus.Rsp_Valid), 64'd1);
        chk("hold1_data", 64'(bus.Rsp_Data), 64'(hd1));
      end
      if (h0) chk("hold0_data", 64'(bus0.Rsp_Data), 64'(hd0));
      if (bus.Rsp_Valid && bus.Rsp_Ready) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 64'(bus.Rsp_Valid), 64'd0);
        else begin
          e1 = q1.pop_front();
          chk("rsp1_data", 64'(bus.Rsp_Data), 64'(e1[W-1:0]));
          chk("rsp1_addr", 64'(bus.Rsp_Address), 64'(e1[NB+W-1:W]));
        end
      end
      if (bus0.Rsp_Valid && bus0.Rsp_Ready) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 64'(bus0.Rsp_Valid), 64'd0);
        else begin
          e0 = q0.pop_front();
          chk("rsp0_data", 64'(bus0.Rsp_Data), 64'(e0[W-1:0]));
          chk("rsp0_addr", 64'(bus0.Rsp_Address), 64'(e0[NB+W-1:W]));
        end
      end
      h1 = bus.Rsp_Valid && !bus.Rsp_Ready;
      hd1 = bus.Rsp_Data;
      h0 = bus0.Rsp_Valid && !bus0.Rsp_Ready;
      hd0 = bus0.Rsp_Data;
      if (bus.Rd_Valid && bus.Rd_Ready) q1.push_back({bus.Rd_Address, model(bus.Rd_Address, 1'b1)});
      if (bus0.Rd_Valid && bus0.Rd_Ready) q0.push_back({bus0.Rd_Address, model(bus0.Rd_Address, 1'b0)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [NB-1:0] a, output bit first_rdy);
    bus.Rd_Valid = 1'b1;
    bus.Rd_Address = a;
    first_rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.Rd_Ready) begin
        first_rdy = (k == 0);
        tick();
        return;
      end
    end
    chk("rd_timeout", 64'(bus.Rd_Ready), 64'd1);
  endtask

  task automatic idle();
    bus.Rd_Valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.Rsp_Valid) return;
    end
    chk("rsp_timeout", 64'(bus.Rsp_Valid), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (q1.size() == 0 && q0.size() == 0) return;
      tick();
    end
    chk("drain_pending", 64'(q1.size() + q0.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] = 32'(i * 25);
    bus.Rd_Valid = 1'b1;
    bus.Rd_Address = 5'd3;
    bus.Rsp_Ready = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", 64'(bus.Rsp_Valid), 64'd0);
    chk("rst_data", 64'(bus.Rsp_Data), 64'd0);
    chk("rst_addr", 64'(bus.Rsp_Address), 64'd0);
    chk("rst_valid_z0", 64'(bus0.Rsp_Valid), 64'd0);
    idle();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 64'(bus.Rd_Ready), 64'd1);
    tick();
    rd(5'd3, r);
    idle();
    wait_rsp();
    chk("single_data", 64'(bus.Rsp_Data), 64'd75);
    chk("single_addr", 64'(bus.Rsp_Address), 64'd3);
    tick();
    drain();
    rd(5'd10, r);
    chk("stream_rdy10", 64'(r), 64'd1);
    rd(5'd30, r);
    chk("stream_rdy30", 64'(r), 64'd1);
    rd(5'd31, r);
    chk("stream_rdy31", 64'(r), 64'd1);
    idle();
    drain();
    bus.Rsp_Ready = 1'b0;
    rd(5'd5, r);
    rd(5'd6, r);
    idle();
    tick();
    tick();
    @(negedge clk);
    chk("bp_rdy", 64'(bus.Rd_Ready), 64'd0);
    chk("bp_valid", 64'(bus.Rsp_Valid), 64'd1);
    chk("bp_data", 64'(bus.Rsp_Data), 64'd125);
    tick();
    @(negedge clk);
    chk("bp_data_held", 64'(bus.Rsp_Data), 64'd125);
    tick();
    bus.Rsp_Ready = 1'b1;
    drain();
    regs[0] = 32'hDEADBEEF;
    rd(5'd0, r);
    idle();
    wait_rsp();
    chk("zero_reg1", 64'(bus.Rsp_Data), 64'd0);
    chk("zero_reg0", 64'(bus0.Rsp_Data), 64'hDEADBEEF);
    tick();
    drain();
    rd(5'd12, r);
    regs[12] = 32'h1234;
    idle();
    wait_rsp();
    chk("snapshot", 64'(bus.Rsp_Data), 64'd300);
    tick();
    drain();
    wr_en = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'd99;
    rd(5'd7, r);
    regs[7] = 32'd99;
    wr_en = 1'b0;
    idle();
    wait_rsp();
    chk("bypass", 64'(bus.Rsp_Data), BYPASS ? 64'd99 : 64'd175);
    tick();
    drain();
    for (int i = 0; i < 80; i++) begin
      bus.Rd_Valid = 1'($urandom_range(0, 1));
      bus.Rd_Address = 5'($urandom_range(0, N - 1));
      bus.Rsp_Ready = ($urandom_range(0, 3) != 0);
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 1) != 0) ? bus.Rd_Address : 5'($urandom_range(0, N - 1));
      wr_data = $urandom;
      regs[$urandom_range(0, N - 1)] = $urandom;
      tick();
    end
    idle();
    wr_en = 1'b0;
    bus.Rsp_Ready = 1'b1;
    drain();
    bus.Rsp_Ready = 1'b0;
    rd(5'd1, r);
    rd(5'd2, r);
    idle();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(bus.Rsp_Valid), 64'd0);
    chk("midrst_rdy", 64'(bus.Rd_Ready), 64'd1);
    tick();
    bus.Rsp_Ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rd(5'd4, r);
    idle();
    drain();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end
endmodule
